// File: rtl/fetch_prefetch_if.sv
// Handshake bundle between the prefetcher, instruction memory and the
// instruction FIFO. The prefetcher uses the master view; the environment
// (memory plus FIFO) uses the slave view.
interface fetch_prefetch_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int CW   = 2
);
  // Control from the pipeline front end
  logic            FETCH_EN;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  // Instruction memory read port
  logic            MEM_REQ;
  logic [XLEN-1:0] MEM_ADDR;
  logic            MEM_GNT;
  logic            MEM_RVALID;
  logic [ILEN-1:0] MEM_RDATA;
  // Instruction FIFO write side and status
  logic            FIFO_FULL;
  logic [CW-1:0]   FIFO_COUNT;
  logic [ILEN-1:0] FIFO_A;
  logic            FIFO_WE;
  logic            FLUSH;
  logic            ERR;

  modport master (
    input  FETCH_EN, REDIRECT, REDIRECT_PC,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA,
    input  FIFO_FULL, FIFO_COUNT,
    output MEM_REQ, MEM_ADDR, FIFO_A, FIFO_WE, FLUSH, ERR
  );

  modport slave (
    output FETCH_EN, REDIRECT, REDIRECT_PC,
    output MEM_GNT, MEM_RVALID, MEM_RDATA,
    output FIFO_FULL, FIFO_COUNT,
    input  MEM_REQ, MEM_ADDR, FIFO_A, FIFO_WE, FLUSH, ERR
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher. Issues reads to instruction memory,
// forwards returned words straight into the instruction FIFO, throttles on
// FIFO occupancy plus in-flight reads, and drops stale responses after a
// redirect.
module fetch_prefetch #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              MAX_OUT    = 2,
  parameter int              CW         = $clog2(FIFO_DEPTH)
) (
  input logic              CLK,
  input logic              RST,
  fetch_prefetch_if.master bus
);

  // Outstanding counter width and a credit sum width with headroom
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH_WAIT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [OW-1:0]   r_outst;
  logic [OW-1:0]   r_discard;
  logic            r_err;

  state_t          w_state_next;
  logic [OW-1:0]   w_outst_next;
  logic [OW-1:0]   w_discard_next;
  logic [SW-1:0]   w_occ;
  logic            w_credit_ok;
  logic            w_rsp_ok;
  logic            w_req;
  logic            w_gnt;
  logic [OW-1:0]   w_outst_after_rsp;
  logic [ILEN-1:0] w_rdata;

  // A full FIFO reports count 0, so full is folded in as the whole depth
  assign w_occ = bus.FIFO_FULL ? SW'(FIFO_DEPTH) : SW'(bus.FIFO_COUNT);

  // Reserve a FIFO slot for every in-flight read before issuing another
  assign w_credit_ok = ((w_occ + SW'(r_outst)) < SW'(FIFO_DEPTH)) &&
                       (r_outst < OW'(MAX_OUT));

  // A response only counts against tracking when something is in flight
  assign w_rsp_ok          = bus.MEM_RVALID && (r_outst != '0);
  assign w_outst_after_rsp = r_outst - OW'(w_rsp_ok);

  assign w_req = (r_state == S_RUN) && w_credit_ok && !bus.REDIRECT;
  assign w_gnt = w_req && bus.MEM_GNT;

  assign w_rdata      = bus.MEM_RDATA;
  assign bus.MEM_REQ  = w_req;
  assign bus.MEM_ADDR = r_pc;
  assign bus.FIFO_A   = w_rdata;
  assign bus.FIFO_WE  = w_rsp_ok && (r_state != S_FLUSH_WAIT) && !bus.REDIRECT;
  assign bus.FLUSH    = bus.REDIRECT;
  assign bus.ERR      = r_err;

  // Next-state and tracking counters; redirect overrides everything else
  always_comb begin
    w_state_next   = r_state;
    w_outst_next   = r_outst;
    w_discard_next = r_discard;
    if (bus.REDIRECT) begin
      // Everything still in flight (minus one arriving now) is stale
      w_outst_next   = w_outst_after_rsp;
      w_discard_next = w_outst_after_rsp;
      if (w_outst_after_rsp != '0) begin
        w_state_next = S_FLUSH_WAIT;
      end else begin
        w_state_next = bus.FETCH_EN ? S_RUN : S_IDLE;
      end
    end else begin
      w_outst_next = w_outst_after_rsp + OW'(w_gnt);
      case (r_state)
        S_IDLE: begin
          if (bus.FETCH_EN) w_state_next = S_RUN;
        end
        S_RUN: begin
          if (!bus.FETCH_EN) w_state_next = S_IDLE;
        end
        S_FLUSH_WAIT: begin
          w_discard_next = r_discard - OW'(bus.MEM_RVALID && (r_discard != '0));
          if (w_discard_next == '0) begin
            w_state_next = bus.FETCH_EN ? S_RUN : S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State, counters and sticky error; PC follows grants or redirects
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_outst   <= w_outst_next;
      r_discard <= w_discard_next;
      if (bus.REDIRECT) begin
        r_pc <= bus.REDIRECT_PC;
      end else if (w_gnt) begin
        r_pc <= r_pc + XLEN'(4);
      end
      if (bus.MEM_RVALID && (r_outst == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a memory model with selectable read
// latency, a depth-4 FIFO occupancy model, and a scoreboard that checks
// every granted address and every FIFO write against hand-built queues.
module tb_fetch_prefetch;

  localparam int MAX_OUT = 2;

  logic clk;
  logic rst;

  fetch_prefetch_if #(.XLEN(32), .ILEN(32), .CW(2)) bus ();

  fetch_prefetch #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          gcnt = 0;
  int          wcnt = 0;
  int          bout = 0;
  int          lat  = 2;
  int          fcount = 0;
  bit          rd_en = 1'b1;
  bit          spur_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h13 + (a << 5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input bit wr);
    exp_addr.push_back(a);
    if (wr) exp_data.push_back(mem_word(a));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    bus.FETCH_EN = 1'b1;
    bus.MEM_GNT = 1'b1;
    bus.REDIRECT = 1'b0;
    rd_en = 1'b1;
    tick();
    tick();
    gcnt = 0;
    wcnt = 0;
    rst = 1'b1;
  endtask

  task automatic stop_after(input string nm, input int n);
    for (int i = 0; i < 60 && gcnt < n; i++) tick();
    chk({nm, "_grants"}, gcnt, n);
    bus.MEM_GNT = 1'b0;
    bus.FETCH_EN = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30 && exp_data.size() > 0; i++) tick();
    chk({nm, "_data_left"}, exp_data.size(), 0);
    chk({nm, "_addr_left"}, exp_addr.size(), 0);
  endtask

  // Memory with 2- or 3-cycle read latency plus the downstream FIFO count
  initial begin
    bit          pv[0:2];
    logic [31:0] pa[0:2];
    bit          g, we, fl, rv, rdv;
    logic [31:0] ga;
    bit          vld;
    logic [31:0] va;
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0;
      pa[k] = '0;
    end
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA = '0;
    bus.FIFO_FULL = 1'b0;
    bus.FIFO_COUNT = '0;
    forever begin
      @(negedge clk);
      g   = bus.MEM_REQ && bus.MEM_GNT;
      ga  = bus.MEM_ADDR;
      we  = bus.FIFO_WE;
      fl  = bus.FLUSH;
      rv  = bus.MEM_RVALID;
      rdv = rd_en;
      if (!rst) begin
        bout = 0;
      end else begin
        if (g) bout++;
        if (rv && bout > 0) bout--;
        if (g) chk("outst_cap", (bout <= MAX_OUT), 1);
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;
        fcount = 0;
      end else begin
        pv[2] = pv[1]; pa[2] = pa[1];
        pv[1] = pv[0]; pa[1] = pa[0];
        pv[0] = g;     pa[0] = ga;
        if (fl) fcount = 0;
        else fcount = fcount + (we ? 1 : 0) - ((rdv && fcount > 0) ? 1 : 0);
      end
      vld = (lat == 3) ? pv[2] : pv[1];
      va  = (lat == 3) ? pa[2] : pa[1];
      bus.MEM_RVALID = vld || spur_req;
      bus.MEM_RDATA  = vld ? mem_word(va) : 32'hDEADBEEF;
      spur_req = 1'b0;
      bus.FIFO_FULL  = (fcount >= 4);
      bus.FIFO_COUNT = 2'(fcount);
    end
  end

  // Scoreboard monitor: every grant and every FIFO write pops an expectation
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.MEM_REQ && bus.MEM_GNT) begin
          gcnt++;
          if (exp_addr.size() == 0) begin
            chk("grant_unexpected", bus.MEM_ADDR, 32'hxxxxxxxx);
          end else begin
            e = exp_addr.pop_front();
            chk("grant_addr", bus.MEM_ADDR, e);
          end
        end
        if (bus.FIFO_WE) begin
          wcnt++;
          chk("we_while_full", bus.FIFO_FULL, 1'b0);
          if (exp_data.size() == 0) begin
            chk("write_unexpected", bus.FIFO_A, 32'hxxxxxxxx);
          end else begin
            e = exp_data.pop_front();
            chk("fifo_a", bus.FIFO_A, e);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    rst = 1'b0;
    bus.FETCH_EN = 1'b1;
    bus.REDIRECT = 1'b0;
    bus.REDIRECT_PC = '0;
    bus.MEM_GNT = 1'b1;
    repeat (3) tick();

    // Outputs held in reset; FLUSH still follows REDIRECT
    chk("rst_req", bus.MEM_REQ, 0);
    chk("rst_we", bus.FIFO_WE, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_addr", bus.MEM_ADDR, 32'h0);
    tick();
    bus.REDIRECT = 1'b1;
    #1;
    chk("rst_flush", bus.FLUSH, 1);
    tick();
    bus.REDIRECT = 1'b0;

    // Reset and start: sequential fetch, two in flight at most
    for (int i = 0; i < 6; i++) push(32'(i * 4), 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("start_idle_req", bus.MEM_REQ, 0);
    tick();
    chk("start_req", bus.MEM_REQ, 1);
    chk("start_addr0", bus.MEM_ADDR, 32'h0);
    tick();
    chk("start_addr1", bus.MEM_ADDR, 32'h4);
    tick();
    chk("start_addr2", bus.MEM_ADDR, 32'h8);
    chk("start_cap_req", bus.MEM_REQ, 0);
    stop_after("start", 6);
    drain("start");
    repeat (3) tick();

    // Back-pressure: no downstream reads, exactly four words fit
    for (int i = 0; i < 4; i++) push(32'h18 + 32'(i * 4), 1'b1);
    rd_en = 1'b0;
    gcnt = 0;
    wcnt = 0;
    bus.FETCH_EN = 1'b1;
    bus.MEM_GNT = 1'b1;
    repeat (20) tick();
    chk("bp_writes", wcnt, 4);
    chk("bp_grants", gcnt, 4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_off", bus.MEM_REQ, 0);
      tick();
    end
    push(32'h28, 1'b1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (10) tick();
    chk("bp_one_more_write", wcnt, 5);
    chk("bp_one_more_grant", gcnt, 5);
    chk("bp_req_off_again", bus.MEM_REQ, 0);

    // Grant stall at 0x8
    do_reset();
    for (int i = 0; i < 3; i++) push(32'(i * 4), 1'b1);
    for (int i = 0; i < 10 && gcnt < 2; i++) tick();
    chk("stall_pre_grants", gcnt, 2);
    bus.MEM_GNT = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MEM_REQ) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", bus.MEM_REQ, 1);
      chk("stall_addr", bus.MEM_ADDR, 32'h8);
      tick();
    end
    bus.MEM_GNT = 1'b1;
    #1;
    chk("stall_gnt_addr", bus.MEM_ADDR, 32'h8);
    tick();
    chk("stall_next_addr", bus.MEM_ADDR, 32'hC);
    bus.MEM_GNT = 1'b0;
    bus.FETCH_EN = 1'b0;
    drain("stall");

    // Redirect with two in flight and no response in the redirect cycle
    lat = 3;
    do_reset();
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(i * 4), 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bout == 2 && !bus.MEM_RVALID) break;
    end
    chk("redir_inflight", bout, 2);
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h100;
    #1;
    chk("redir_flush", bus.FLUSH, 1);
    chk("redir_req", bus.MEM_REQ, 0);
    tick();
    bus.REDIRECT = 1'b0;
    #1;
    chk("redir_wait1_req", bus.MEM_REQ, 0);
    chk("redir_wait1_we", bus.FIFO_WE, 0);
    tick();
    chk("redir_wait2_req", bus.MEM_REQ, 0);
    chk("redir_wait2_we", bus.FIFO_WE, 0);
    tick();
    chk("redir_resume_req", bus.MEM_REQ, 1);
    chk("redir_resume_addr", bus.MEM_ADDR, 32'h100);
    stop_after("redir", 5);
    drain("redir");

    // Redirect coinciding with a response, to the top of the address space
    lat = 2;
    do_reset();
    push(32'h0, 1'b0);
    push(32'h4, 1'b0);
    push(32'hFFFFFFFC, 1'b1);
    push(32'h0, 1'b1);
    push(32'h4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bout == 2 && bus.MEM_RVALID) break;
    end
    chk("corner_inflight", bout, 2);
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'hFFFFFFFC;
    #1;
    chk("corner_we", bus.FIFO_WE, 0);
    chk("corner_flush", bus.FLUSH, 1);
    tick();
    bus.REDIRECT = 1'b0;
    #1;
    chk("corner_wait_req", bus.MEM_REQ, 0);
    chk("corner_wait_we", bus.FIFO_WE, 0);
    tick();
    chk("corner_resume_req", bus.MEM_REQ, 1);
    chk("corner_resume_addr", bus.MEM_ADDR, 32'hFFFFFFFC);
    tick();
    chk("corner_wrap_addr", bus.MEM_ADDR, 32'h0);
    stop_after("corner", 5);
    drain("corner");

    // Spurious response with nothing outstanding
    repeat (2) tick();
    chk("spur_err_before", bus.ERR, 0);
    spur_req = 1'b1;
    tick();
    chk("spur_we", bus.FIFO_WE, 0);
    tick();
    chk("spur_err_set", bus.ERR, 1);
    repeat (3) tick();
    chk("spur_err_sticky", bus.ERR, 1);
    rst = 1'b0;
    #1;
    chk("spur_err_cleared", bus.ERR, 0);
    tick();
    rst = 1'b1;
    tick();

    chk("end_addr_queue", exp_addr.size(), 0);
    chk("end_data_queue", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
